// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and a variable-latency memory (slave).
// The request side is registered in the master; the memory answers with ack plus read data.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word lane steering, load extension, misalignment check and a
// bus watchdog around a req/ack handshake; stalls the core while an access is outstanding.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [1:0]               MemSize,
    input  logic                     MemSigned,
    input  logic [31:0]              ALUresult,
    input  logic [31:0]              Rt_Data,
    output logic [31:0]              ReadData,
    output logic                     stall,
    output logic                     misaligned,
    output logic                     bus_error,
    load_store_unit_if.master        mem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rd_q, rd_d;
    logic             mis_q, mis_d;
    logic             berr_q, berr_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;
    logic             sgn_q, sgn_d;

    logic             acc;
    logic             illegal;
    logic [3:0]       be_in;
    logic [31:0]      wdata_in;
    logic [31:0]      lane;
    logic [31:0]      load_ext;
    logic             stall_c;

    // Legality, byte enables and lane-replicated store data from the presented instruction
    always_comb begin
        acc      = MemRead | MemWrite;
        illegal  = 1'b0;
        be_in    = 4'b0000;
        wdata_in = Rt_Data;
        case (MemSize)
            2'b00: begin
                be_in    = 4'b0001 << ALUresult[1:0];
                wdata_in = {4{Rt_Data[7:0]}};
            end
            2'b01: begin
                be_in    = ALUresult[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{Rt_Data[15:0]}};
                illegal  = ALUresult[0];
            end
            2'b10: begin
                be_in    = 4'b1111;
                illegal  = |ALUresult[1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Load lane select and extension, driven by the fields latched when the request was issued
    always_comb begin
        lane = mem.mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = sgn_q ? {{24{lane[7]}}, lane[7:0]}   : {24'b0, lane[7:0]};
            2'b01:   load_ext = sgn_q ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        size_d  = size_q;
        off_d   = off_q;
        sgn_d   = sgn_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    stall_c = 1'b1;
                    if (illegal) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                        if (!MemWrite) rd_d = '0;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = MemWrite;
                        addr_d  = {ALUresult[31:2], 2'b00};
                        be_d    = be_in;
                        wdata_d = wdata_in;
                        cnt_d   = '0;
                        size_d  = MemSize;
                        off_d   = ALUresult[1:0];
                        sgn_d   = MemSigned;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                // An ack in the final watchdog cycle still completes the access normally
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) rd_d = load_ext;
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    state_d = DONE;
                    if (!we_q) rd_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            size_q  <= size_d;
            off_q   <= off_d;
            sgn_q   <= sgn_d;
        end
    end

    // Stall is released while reset is held so the core is never frozen by an abandoned access
    assign stall         = stall_c & rst_n;
    assign ReadData      = rd_q;
    assign misaligned    = mis_q;
    assign bus_error     = berr_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: each access pushes its predicted outcome to a scoreboard queue that is
// popped and compared when the DUT reaches its completion cycle (stall released).
module tb_load_store_unit;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        berr;
        int          stalls;
        int          reqs;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0, MemSigned = 1'b0;
    logic [1:0]  MemSize = 2'b00;
    logic [31:0] ALUresult = '0, Rt_Data = '0;
    logic [31:0] ReadData;
    logic        stall, misaligned, bus_error;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    logic [31:0] model_rd = '0;

    load_store_unit_if mem ();

    load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
        .ALUresult(ALUresult), .Rt_Data(Rt_Data),
        .ReadData(ReadData), .stall(stall), .misaligned(misaligned), .bus_error(bus_error),
        .mem(mem)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rdat, input int waits,
                                   input logic [31:0] prev_rd);
        exp_t        e;
        logic        ill;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ld;
        e.we   = wr;
        e.addr = {a[31:2], 2'b00};
        e.mis  = 1'b0;
        e.berr = 1'b0;
        e.rd   = prev_rd;
        e.be   = 4'b0000;
        e.wdata = wd;
        ill    = 1'b0;
        b = rdat[int'(a[1:0]) * 8 +: 8];
        h = a[1] ? rdat[31:16] : rdat[15:0];
        ld = rdat;
        case (sz)
            2'b00: begin
                e.be = 4'b0001 << a[1:0]; e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
                ld = sg ? {{24{b[7]}}, b} : {24'h0, b};
            end
            2'b01: begin
                e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {wd[15:0], wd[15:0]};
                ill = a[0];
                ld = sg ? {{16{h[15]}}, h} : {16'h0, h};
            end
            2'b10: begin e.be = 4'b1111; ill = (a[1:0] != 2'b00); end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            e.mis = 1'b1; e.stalls = 1; e.reqs = 0;
            if (!wr) e.rd = '0;
        end else if (waits < 0) begin
            e.berr = 1'b1; e.stalls = 1 + TO; e.reqs = TO;
            if (!wr) e.rd = '0;
        end else begin
            e.stalls = 2 + waits; e.reqs = 1 + waits;
            if (!wr) e.rd = ld;
        end
        return e;
    endfunction

    // waits < 0: memory never acknowledges
    task automatic access(input string name, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits);
        exp_t e;
        int   stalls = 0, reqs = 0;
        bit   done = 0;
        logic got_mis = 1'b0, got_berr = 1'b0;
        logic [31:0] got_rd = '0;
        e = model(wr, sz, sg, a, wd, rdat, waits, model_rd);
        sb_q.push_back(e);
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
        ALUresult = a; Rt_Data = wd;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (stall) stalls++;
            else begin
                done = 1; got_mis = misaligned; got_berr = bus_error; got_rd = ReadData;
            end
            if (mem.mem_req) begin
                reqs++;
                check_eq({name, ".be"}, {28'h0, mem.mem_be}, {28'h0, e.be});
                check_eq({name, ".addr"}, mem.mem_addr, e.addr);
                check_eq({name, ".wdata"}, mem.mem_wdata, e.wdata);
                check_eq({name, ".we"}, {31'h0, mem.mem_we}, {31'h0, e.we});
                mem.mem_ack = (waits >= 0) && (reqs > waits);
                mem.mem_rdata = rdat;
                // inputs must be ignored once the request is latched
                ALUresult = $urandom; Rt_Data = $urandom;
            end else begin
                mem.mem_ack = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        MemRead = 1'b0; MemWrite = 1'b0; mem.mem_ack = 1'b0;
        if (!done) check_eq({name, ".completion_budget"}, 32'd0, 32'd1);
        if (sb_q.size() == 0) check_eq({name, ".scoreboard_empty"}, 32'd0, 32'd1);
        else begin
            e = sb_q.pop_front();
            check_eq({name, ".stall_cycles"}, stalls, e.stalls);
            check_eq({name, ".req_cycles"}, reqs, e.reqs);
            check_eq({name, ".misaligned"}, {31'h0, got_mis}, {31'h0, e.mis});
            check_eq({name, ".bus_error"}, {31'h0, got_berr}, {31'h0, e.berr});
            check_eq({name, ".ReadData"}, got_rd, e.rd);
            model_rd = e.rd;
        end
        #1;
        check_eq({name, ".post_flags"}, {30'h0, misaligned, bus_error}, 32'h0);
        check_eq({name, ".post_idle"}, {30'h0, stall, mem.mem_req}, 32'h0);
        $display("txn %-10s stalls=%0d reqs=%0d mis=%0b berr=%0b ReadData=0x%08h",
                 name, stalls, reqs, got_mis, got_berr, got_rd);
    endtask

    initial begin
        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.outs", {28'h0, stall, misaligned, bus_error, mem.mem_req}, 32'h0);
        check_eq("reset.ReadData", ReadData, 32'h0);
        check_eq("reset.bus", mem.mem_addr | mem.mem_wdata | {28'h0, mem.mem_be} | {31'h0, mem.mem_we}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        access("ld_word",  1, 0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0);
        access("ld_bs",    1, 0, 2'b00, 1, 32'h203, 32'h0,        32'h80AABBCC, 0);
        access("ld_bu",    1, 0, 2'b00, 0, 32'h203, 32'h0,        32'h80AABBCC, 0);
        access("st_half",  0, 1, 2'b01, 0, 32'h302, 32'h1234ABCD, 32'h0,        3);
        access("ld_mis",   1, 0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        0);
        access("ld_sz11",  1, 0, 2'b11, 0, 32'h200, 32'h0,        32'h0,        0);
        access("ld_hs",    1, 0, 2'b01, 1, 32'h302, 32'h0,        32'h80017FFF, 1);
        access("st_both",  1, 1, 2'b00, 0, 32'h201, 32'h00000055, 32'hFFFFFFFF, 0);
        access("ld_hu",    1, 0, 2'b01, 0, 32'h300, 32'h0,        32'h12349876, 2);
        access("st_mis",   0, 1, 2'b01, 0, 32'h303, 32'hCAFEF00D, 32'h0,        0);
        access("ld_tmo",   1, 0, 2'b10, 0, 32'h500, 32'h0,        32'h11111111, -1);

        // late ack arriving while idle must be ignored
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h77777777;
        @(posedge clk); #1;
        mem.mem_ack = 1'b0;
        @(posedge clk); #1;
        check_eq("late_ack.ReadData", ReadData, model_rd);
        check_eq("late_ack.outs", {28'h0, stall, misaligned, bus_error, mem.mem_req}, 32'h0);

        // reset while a load is waiting
        MemRead = 1'b1; MemSize = 2'b10; ALUresult = 32'h400;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("rst_mid.req_before", {31'h0, mem.mem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid.req", {31'h0, mem.mem_req}, 32'h0);
        check_eq("rst_mid.stall", {31'h0, stall}, 32'h0);
        check_eq("rst_mid.ReadData", ReadData, 32'h0);
        model_rd = '0;
        @(posedge clk); #1;
        MemRead = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access("ld_after", 1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0BADF00D, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Uses ALUresult as the effective address and Rt_Data as the store data.
- Runs a req/ack handshake to a variable-latency data memory and stalls the core until the access completes.
- Performs byte/half/word lane steering, load sign/zero extension, misalignment detection and a bus-timeout watchdog.

Parameters:
TIMEOUT_CYCLES, 16, max REQ-state cycles without mem_ack before bus error; 0 disables the watchdog
CNT_W, 8, width of the watchdog counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
MemRead  input  1  current instruction is a load
MemWrite  input  1  current instruction is a store; has priority over MemRead
MemSize  input  2  00 byte, 01 half, 10 word, 11 illegal
MemSigned  input  1  1 = sign-extend a byte/half load, 0 = zero-extend
ALUresult  input  32  effective byte address
Rt_Data  input  32  store data, right-aligned
ReadData  output  32  extended load result, registered
stall  output  1  combinational; freezes PC and pipeline while high
misaligned  output  1  one-cycle pulse in DONE for a misaligned or illegal access
bus_error  output  1  one-cycle pulse in DONE after a watchdog timeout
mem_req  output  1  registered request to memory
mem_we  output  1  registered; 1 = write
mem_addr  output  32  registered word address {addr[31:2],2'b00}
mem_be  output  4  registered byte enables; bit i = byte lane i (little-endian)
mem_wdata  output  32  registered, lane-replicated store data
mem_rdata  input  32  read data; valid when mem_ack=1
mem_ack  input  1  access complete; sampled only in REQ

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - ReadData, misaligned, bus_error, mem_req, mem_we, mem_addr, mem_be and mem_wdata all 0.
  - Reset mid-access drops mem_req immediately; the outstanding access is abandoned.
- States: IDLE, REQ, DONE.
- IDLE, no access (MemRead=MemWrite=0): stall=0, remain IDLE.
- IDLE, access present (acc = MemRead|MemWrite), legality checked:
  - Illegal if MemSize=11, or half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal: stall=1, go to DONE with the misaligned flag set; no memory request is issued.
  - Legal: stall=1, register mem_addr/mem_be/mem_wdata, set mem_we=MemWrite, mem_req=1, counter=0, go to REQ.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- mem_wdata lane replication:
  - byte: {4{Rt_Data[7:0]}}
  - half: {2{Rt_Data[15:0]}}
  - word: Rt_Data
- REQ:
  - stall=1; mem_req held high with address, data and enables stable until mem_ack.
  - mem_ack=1: deassert mem_req and go to DONE. For a load, select the lane from the latched addr[1:0]/size, extend per the latched MemSigned, and register into ReadData.
  - mem_ack=0: counter increments. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1, deassert mem_req, ReadData=0 for a load, set bus_error, go to DONE.
- DONE:
  - stall=0 so the core advances at the end of this cycle.
  - misaligned/bus_error high in this cycle only; a misaligned load also writes ReadData=0.
  - Next state is always IDLE, even if the same instruction is still presented, so there is no re-issue.
- Latency:
  - Ack in the first REQ cycle gives 3 cycles total (IDLE, REQ, DONE).
  - Each extra wait cycle adds 1.
  - A misaligned access takes 2 cycles (IDLE, DONE).
- ReadData holds its value until the next completed load; stores never modify it.
- mem_ack is ignored outside REQ.
- MemRead and MemWrite both high: treated as a store.
- All latched fields come from the IDLE-cycle inputs; input changes during REQ are ignored.

Test Plan:
- Word load: addr 0x100, mem_rdata=0xDEADBEEF with ack in the 1st REQ cycle -> mem_be=1111, mem_addr=0x100, stall high 2 cycles, ReadData=0xDEADBEEF in DONE.
- Byte loads: addr 0x203, mem_rdata=0x80AABBCC, MemSigned=1 -> mem_be=1000, ReadData=0xFFFFFF80. Same with MemSigned=0 -> ReadData=0x00000080.
- Half store: addr 0x302, Rt_Data=0x1234ABCD, ack after 3 wait cycles -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, stall high 5 cycles, ReadData unchanged.
- Misaligned: word load at addr 0x101 -> mem_req never asserts, misaligned pulses for 1 cycle, ReadData=0, stall high 1 cycle. MemSize=11 behaves the same way.
- Timeout: TIMEOUT_CYCLES=4, ack never arrives -> mem_req high 4 cycles then low, bus_error 1-cycle pulse, ReadData=0. A late ack arriving in IDLE is ignored.
- Reset mid-REQ: rst_n low during a wait -> mem_req=0 and stall=0 at once. After release, a new load at 0x0 completes normally.
